out_port_bank: RTL and testbench
================================

# out_port_bank

Parametrised multi-channel output port for the RISC-CPU datapath. It replaces the single-register OutPort with CHANNELS independent FIFO-buffered channels. Each channel is written from BusMuxOut during the `out` instruction's T3 step and drains to an external device over a valid/ready handshake. Full and overflow status are reported back to the control unit.

## Interface
- DATA_W, 32, width of bus word and of each channel's data
- CHANNELS, 4, number of output channels (1..16)
- DEPTH, 4, FIFO entries per channel (power of two, ≥2)
- Clock  in  1  system clock, rising edge active
- Reset  in  1  asynchronous, active-high; clears all state
- BusMuxOut  in  DATA_W  datapath bus word to be written
- OutPortin  in  1  write strobe, level; may be held for several cycles
- port_sel  in  max(1,$clog2(CHANNELS))  target channel, taken from the Gra-selected register field
- ovf_clr  in  1  synchronous clear of overflow
- OutPortout  in  1  readback enable (see Configuration)
- readback  out  DATA_W  last word written to port_sel channel
- port_busy  out  1  selected channel full (combinational from port_sel)
- port_full  out  CHANNELS  per-channel full flags
- overflow  out  1  sticky: a write was dropped
- ext_data  out  CHANNELS*DATA_W  channel c head word at bits [c*DATA_W +: DATA_W]
- ext_valid  out  CHANNELS  channel c head word valid
- ext_ready  in  CHANNELS  external device accepts channel c head

## Operation
- Write detect: register wr_prev <= OutPortin each edge. wr_req = OutPortin & ~wr_prev, so one write occurs per strobe assertion regardless of hold length.
- On an edge with wr_req:
  - If port_sel < CHANNELS and count[port_sel] < DEPTH: push BusMuxOut and update last[port_sel].
  - Otherwise: word dropped, overflow <= 1.
- Pop: on every edge where ext_valid[c] & ext_ready[c], advance channel c read pointer and decrement its count.
- Per channel:
  - Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits.
  - ext_valid[c] = (count != 0). ext_data = mem[rd_ptr].
  - port_full[c] = (count == DEPTH).
- Simultaneous push and pop on the same channel:
  - Not full: both happen, count unchanged.
  - Full: push is evaluated against the pre-edge count and dropped (overflow set); pop still happens.
- Pops on all channels are independent and concurrent.
- overflow: set has priority over ovf_clr in the same cycle.
- Reset asserted mid-operation:
  - Immediately clears all counts, pointers, last[], overflow and wr_prev.
  - All ext_valid go 0. Queued data is lost.
- OutPortin held high across Reset deassertion is seen as a rising edge on the first clock edge after release, and writes once.

## Timing
- Reset values: ext_valid=0, port_full=0, port_busy=0, overflow=0, readback=0, ext_data=0 (memory contents are don't-care but masked to 0 while empty).
- Write latency: data is on ext_data and ext_valid=1 one edge after the accepting edge.
- Minimum FIFO residency: 1 cycle. A push into an empty channel with ext_ready held high pops on the second edge.
- Throughput per channel: one pop per cycle. Writes are limited to one per strobe assertion, so at most one per 2 cycles.
- port_busy and readback: combinational from registered state and port_sel, no added latency.
- port_full and overflow: update on the same edge as the causing push or pop.

## Configuration
- OUT_PORT_READBACK_EN
  - Defined: readback = OutPortout ? last[port_sel] : 0, letting `in`-style reads return the last value written to a channel.
  - Undefined: last[] registers are not built, readback is tied to 0, and OutPortout is ignored.
  - All other behaviour is identical in both cases.

## Test plan
- Reset, then OutPortin held high 3 cycles with BusMuxOut=0x000000A5, port_sel=1, ext_ready=0 -> exactly one word; ext_valid=4'b0010, ext_data[63:32]=0xA5.
- 5 strobed writes 0x1..0x5 to channel 2 with ext_ready[2]=0 -> port_full[2]=1 after the 4th, 5th dropped, overflow=1; after ovf_clr, overflow=0.
- Channel 0 full and ext_ready[0]=1 in the same cycle as a write of 0x99 -> 0x99 dropped, overflow=1, count goes to 3, pops yield 0x1,0x2,0x3,0x4 in order.
- 10 writes interleaved with pops on channel 3 -> pointers wrap and output order matches input order, with no loss.
- Reset asserted between edges with 2 words queued -> ext_valid=0 and port_full=0 immediately, before the next Clock edge.
- With OUT_PORT_READBACK_EN: write 0xDEADBEEF to channel 1, port_sel=1, OutPortout=1 -> readback=0xDEADBEEF; without the macro -> readback=0.

Source files
------------

// File: rtl/out_port_bank.sv
// Multi-channel FIFO-buffered output port: edge-detected bus writes, valid/ready drain per channel.
// Optional macro OUT_PORT_READBACK_EN builds per-channel last-written registers for readback.
module out_port_bank #(
  parameter  int DATA_W   = 32,
  parameter  int CHANNELS = 4,
  parameter  int DEPTH    = 4,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [DATA_W-1:0]          BusMuxOut,
  input  logic                       OutPortin,
  input  logic [SEL_W-1:0]           port_sel,
  input  logic                       ovf_clr,
  input  logic                       OutPortout,
  output logic [DATA_W-1:0]          readback,
  output logic                       port_busy,
  output logic [CHANNELS-1:0]        port_full,
  output logic                       overflow,
  output logic [CHANNELS*DATA_W-1:0] ext_data,
  output logic [CHANNELS-1:0]        ext_valid,
  input  logic [CHANNELS-1:0]        ext_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic wr_prev;
  logic wr_req;
  logic sel_ok;
  logic sel_full;
  logic drop;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) wr_prev <= 1'b0;
    else       wr_prev <= OutPortin;
  end

  // A held strobe writes only once, on its first cycle high.
  assign wr_req = OutPortin & ~wr_prev;
  assign sel_ok = ({{(32-SEL_W){1'b0}}, port_sel} < 32'(CHANNELS));

  always_comb begin
    sel_full = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (port_sel == SEL_W'(c)) sel_full = port_full[c];
    end
  end

  assign port_busy = sel_full;
  assign drop      = wr_req & (~sel_ok | sel_full);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef OUT_PORT_READBACK_EN
  logic [CHANNELS*DATA_W-1:0] last_flat;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    // Fullness is judged on the pre-edge count, so a full channel drops even while popping.
    assign push = wr_req & (port_sel == SEL_W'(c)) & (count != CNT_W'(DEPTH));
    assign pop  = ext_valid[c] & ext_ready[c];

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge Clock) begin
      if (push) mem[wr_ptr] <= BusMuxOut;
    end

    assign ext_valid[c] = (count != '0);
    assign port_full[c] = (count == CNT_W'(DEPTH));
    assign ext_data[c*DATA_W +: DATA_W] = ext_valid[c] ? mem[rd_ptr] : '0;

`ifdef OUT_PORT_READBACK_EN
    logic [DATA_W-1:0] last;

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)     last <= '0;
      else if (push) last <= BusMuxOut;
    end

    assign last_flat[c*DATA_W +: DATA_W] = last;
`endif
  end

`ifdef OUT_PORT_READBACK_EN
  always_comb begin
    readback = '0;
    if (OutPortout) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (port_sel == SEL_W'(c)) readback = last_flat[c*DATA_W +: DATA_W];
      end
    end
  end
`else
  logic unused_outportout;
  assign unused_outportout = OutPortout;
  assign readback = '0;
`endif

endmodule

// File: tb/tb_out_port_bank.sv
// Scoreboard bench for out_port_bank: expected pops are queued per channel, a forked monitor checks them.
module tb_out_port_bank;

  logic         Clock;
  logic         Reset;
  logic [31:0]  BusMuxOut;
  logic         OutPortin;
  logic [1:0]   port_sel;
  logic         ovf_clr;
  logic         OutPortout;
  logic [31:0]  readback;
  logic         port_busy;
  logic [3:0]   port_full;
  logic         overflow;
  logic [127:0] ext_data;
  logic [3:0]   ext_valid;
  logic [3:0]   ext_ready;

  int vectors;
  int miscompares;
  logic [31:0] exp_q [4][$];

  out_port_bank #(.DATA_W(32), .CHANNELS(4), .DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .BusMuxOut(BusMuxOut), .OutPortin(OutPortin),
    .port_sel(port_sel), .ovf_clr(ovf_clr), .OutPortout(OutPortout),
    .readback(readback), .port_busy(port_busy), .port_full(port_full),
    .overflow(overflow), .ext_data(ext_data), .ext_valid(ext_valid),
    .ext_ready(ext_ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One strobed write; the expected word is queued only when the channel should accept it.
  task automatic applyStimulus(input int ch, input logic [31:0] d, input bit accept);
    port_sel  = 2'(ch);
    BusMuxOut = d;
    OutPortin = 1'b1;
    if (accept) exp_q[ch].push_back(d);
    tick();
    OutPortin = 1'b0;
    tick();
  endtask

  task automatic monitorLoop();
    logic [31:0] exp;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        for (int c = 0; c < 4; c++) begin
          if (ext_valid[c] && ext_ready[c]) begin
            if (exp_q[c].size() == 0) begin
              vectors++;
              miscompares++;
              $display("[TB] FAIL ch%0d_pop: got %0h expected no word", c, ext_data[c*32 +: 32]);
            end else begin
              exp = exp_q[c].pop_front();
              checkOutput($sformatf("ch%0d_pop", c), 128'(ext_data[c*32 +: 32]), 128'(exp));
            end
          end
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset       = 1'b1;
    BusMuxOut   = '0;
    OutPortin   = 1'b0;
    port_sel    = '0;
    ovf_clr     = 1'b0;
    OutPortout  = 1'b0;
    ext_ready   = '0;
    fork
      monitorLoop();
    join_none

    tick(2);
    checkOutput("rst_valid", 128'(ext_valid), 128'h0);
    checkOutput("rst_full", 128'(port_full), 128'h0);
    checkOutput("rst_busy", 128'(port_busy), 128'h0);
    checkOutput("rst_ovf", 128'(overflow), 128'h0);
    checkOutput("rst_readback", 128'(readback), 128'h0);
    checkOutput("rst_data", ext_data, 128'h0);
    Reset = 1'b0;
    tick();

    // Held strobe writes exactly once.
    port_sel  = 2'd1;
    BusMuxOut = 32'h000000A5;
    OutPortin = 1'b1;
    exp_q[1].push_back(32'h000000A5);
    tick(3);
    OutPortin = 1'b0;
    tick();
    checkOutput("hold_valid", 128'(ext_valid), 128'h2);
    checkOutput("hold_data", 128'(ext_data[63:32]), 128'hA5);
    checkOutput("hold_ovf", 128'(overflow), 128'h0);
    ext_ready[1] = 1'b1;
    tick();
    ext_ready[1] = 1'b0;
    tick();
    checkOutput("hold_drained", 128'(ext_valid), 128'h0);

    // Fill channel 2, overflow on the fifth write, then clear it.
    for (int i = 1; i <= 4; i++) applyStimulus(2, 32'(i), 1'b1);
    checkOutput("fill_full", 128'(port_full), 128'h4);
    checkOutput("fill_busy", 128'(port_busy), 128'h1);
    applyStimulus(2, 32'h5, 1'b0);
    checkOutput("fill_ovf", 128'(overflow), 128'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("ovf_cleared", 128'(overflow), 128'h0);
    ext_ready[2] = 1'b1;
    tick(4);
    ext_ready[2] = 1'b0;
    checkOutput("ch2_drained", 128'(ext_valid), 128'h0);

    // Full channel 0 with a concurrent pop: write dropped, pop proceeds.
    for (int i = 1; i <= 4; i++) applyStimulus(0, 32'(i), 1'b1);
    checkOutput("ch0_full", 128'(port_full), 128'h1);
    ext_ready[0] = 1'b1;
    port_sel     = 2'd0;
    BusMuxOut    = 32'h99;
    OutPortin    = 1'b1;
    tick();
    OutPortin = 1'b0;
    checkOutput("fullpop_ovf", 128'(overflow), 128'h1);
    checkOutput("fullpop_full", 128'(port_full), 128'h0);
    tick(3);
    ext_ready[0] = 1'b0;
    checkOutput("ch0_drained", 128'(ext_valid), 128'h0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Interleaved writes and pops on channel 3 wrap the pointers.
    for (int i = 0; i < 10; i++) begin
      ext_ready[3] = (i % 3 != 0);
      applyStimulus(3, 32'h300 + 32'(i), 1'b1);
    end
    ext_ready[3] = 1'b1;
    tick(4);
    ext_ready[3] = 1'b0;
    checkOutput("wrap_ovf", 128'(overflow), 128'h0);
    checkOutput("wrap_drained", 128'(ext_valid), 128'h0);

    // Asynchronous reset with data queued.
    applyStimulus(1, 32'hB1, 1'b1);
    applyStimulus(1, 32'hB2, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(2, 32'hC0 + 32'(i), 1'b1);
    checkOutput("pre_rst_full", 128'(port_full), 128'h4);
    checkOutput("pre_rst_valid", 128'(ext_valid), 128'h6);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("async_valid", 128'(ext_valid), 128'h0);
    checkOutput("async_full", 128'(port_full), 128'h0);
    checkOutput("async_data", ext_data, 128'h0);
    for (int c = 0; c < 4; c++) exp_q[c].delete();

    // Strobe held across reset release writes once.
    port_sel  = 2'd0;
    BusMuxOut = 32'h77;
    OutPortin = 1'b1;
    exp_q[0].push_back(32'h77);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    tick(3);
    OutPortin = 1'b0;
    tick();
    checkOutput("rel_valid", 128'(ext_valid), 128'h1);
    checkOutput("rel_data", 128'(ext_data[31:0]), 128'h77);

    // Readback of the last word written.
    applyStimulus(1, 32'hDEADBEEF, 1'b1);
    OutPortout = 1'b1;
    #1;
`ifdef OUT_PORT_READBACK_EN
    checkOutput("readback_on", 128'(readback), 128'hDEADBEEF);
`else
    checkOutput("readback_on", 128'(readback), 128'h0);
`endif
    OutPortout = 1'b0;
    #1;
    checkOutput("readback_off", 128'(readback), 128'h0);

    ext_ready = 4'hF;
    tick(4);
    ext_ready = 4'h0;
    tick();
    checkOutput("final_valid", 128'(ext_valid), 128'h0);
    for (int c = 0; c < 4; c++)
      checkOutput($sformatf("ch%0d_leftover", c), 128'(exp_q[c].size()), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
